// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with one word per line and flip-flop storage.
// A hit returns data in the same cycle. A miss stalls fetch while the FETCH state fills the line.
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [SETS-1:0]   valid_q;
    logic [TAGW-1:0]   tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDXW-1:0]   req_idx;
    logic [TAGW-1:0]   req_tag;
    logic [IDXW-1:0]   fill_idx;
    logic [TAGW-1:0]   fill_tag;
    logic              hit;
    logic              fill_en;

    assign req_idx  = imemaddr[IDXW+1:2];
    assign req_tag  = imemaddr[31:IDXW+2];
    assign fill_idx = miss_addr_q[IDXW+1:2];
    assign fill_tag = miss_addr_q[31:IDXW+2];

    assign hit      = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                      && (state_q == IDLE);
    assign ihit     = hit;
    assign imemload = data_q[req_idx];
    // iREN depends only on state, so an asynchronous reset drops it at once.
    assign iREN     = (state_q == FETCH);
    assign iaddr    = miss_addr_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    state_d     = FETCH;
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                end
            end
            FETCH: begin
                if (!iwait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (iflush) begin
                valid_q <= '0;
            end
            // The fill is written after the flush, so a line filled during a flush stays valid.
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
                tag_q[fill_idx]   <= fill_tag;
                data_q[fill_idx]  <= iload;
            end
        end
    end
endmodule
